// File: rtl/type_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : type_buffer_if
// Description : Keyboard-event / typed-text bundle between the key decoder,
//               the round timer and the type_buffer. The master side drives
//               key events, the target sentence and round control. The slave
//               side (type_buffer) returns the typed text, the correct mask,
//               the counters and the round state.
// Revision    : 1.0 - initial release
// ============================================================================
interface type_buffer_if #(
  parameter int LEN = 25,
  parameter int CW  = 5
);
  // Key events and round control
  logic              key_valid;
  logic [CW-1:0]     key_code;
  logic [LEN*CW-1:0] target;
  logic              time_up;
  logic              clear;

  // Typed text and round status
  logic [LEN*CW-1:0] typed;
  logic [LEN-1:0]    correct;
  logic [4:0]        len;
  logic [15:0]       keystrokes;
  logic [15:0]       errors;
  logic [1:0]        state;
  logic              start;
  logic              done;

  modport master (
    output key_valid, key_code, target, time_up, clear,
    input  typed, correct, len, keystrokes, errors, state, start, done
  );

  modport slave (
    input  key_valid, key_code, target, time_up, clear,
    output typed, correct, len, keystrokes, errors, state, start, done
  );
endinterface
`default_nettype wire

// File: rtl/type_buffer.sv
`default_nettype none
// ============================================================================
// Module      : type_buffer
// Description : Collects decoded key events into a packed typed-text array,
//               compares each slot against a target sentence latched at round
//               start, and runs the IDLE/TYPING/DONE round state machine with
//               saturating keystroke/error counters.
//               Optional macro STRICT_INPUT_EN: mismatching keys are counted
//               but not inserted.
// Revision    : 1.0 - initial release
// ============================================================================
module type_buffer #(
  parameter int LEN = 25,
  parameter int CW  = 5
) (
  input  wire logic     clk,
  input  wire logic     rst,
  type_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TYPING = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_SPACE = CW'(27);
  localparam logic [CW-1:0] C_BKSP  = CW'(31);
  localparam logic [4:0]    C_LEN   = 5'(LEN);
  localparam logic [15:0]   C_SAT   = 16'hFFFF;

  state_t            state_q, state_d;
  logic [LEN*CW-1:0] typed_q, typed_d;
  logic [LEN-1:0]    correct_q, correct_d;
  logic [4:0]        len_q, len_d;
  logic [15:0]       ks_q, ks_d;
  logic [15:0]       err_q, err_d;
  logic [LEN*CW-1:0] tgt_q, tgt_d;
  logic              start_q, start_d;
  logic              done_q, done_d;

  logic              is_print;
  logic              is_bksp;
  logic              ins_en;
  logic              bks_en;
  logic              write_slot;
  logic              mismatch;
  logic [LEN*CW-1:0] cmp_tgt;
  logic [CW-1:0]     cmp_slot;

  assign is_print = (bus.key_code != '0) && (bus.key_code <= C_SPACE);
  assign is_bksp  = (bus.key_code == C_BKSP);

  // Next-state: round FSM, slot insert/erase, counters; clear overrides all
  always_comb begin
    state_d    = state_q;
    typed_d    = typed_q;
    correct_d  = correct_q;
    len_d      = len_q;
    ks_d       = ks_q;
    err_d      = err_q;
    tgt_d      = tgt_q;
    start_d    = 1'b0;
    ins_en     = 1'b0;
    bks_en     = 1'b0;
    write_slot = 1'b0;
    cmp_tgt    = tgt_q;
    cmp_slot   = '0;

    case (state_q)
      IDLE: begin
        // First printable key opens the round and is compared against the
        // target being latched on this very edge.
        if (bus.key_valid && is_print) begin
          tgt_d   = bus.target;
          cmp_tgt = bus.target;
          start_d = 1'b1;
          state_d = TYPING;
          ins_en  = 1'b1;
        end
      end
      TYPING: begin
        if (bus.key_valid && is_print && (len_q < C_LEN)) ins_en = 1'b1;
        if (bus.key_valid && is_bksp && (len_q != 5'd0)) bks_en = 1'b1;
      end
      default: ;
    endcase

    for (int i = 0; i < LEN; i++) begin
      if (len_q == 5'(i)) cmp_slot = cmp_tgt[i*CW +: CW];
    end
    mismatch = (bus.key_code != cmp_slot);

    if (ins_en) begin
      if (ks_q != C_SAT) ks_d = ks_q + 16'd1;
      if (mismatch && (err_q != C_SAT)) err_d = err_q + 16'd1;
`ifdef STRICT_INPUT_EN
      write_slot = !mismatch;
`else
      write_slot = 1'b1;
`endif
    end

    if (write_slot) begin
      for (int i = 0; i < LEN; i++) begin
        if (len_q == 5'(i)) begin
          typed_d[i*CW +: CW] = bus.key_code;
          correct_d[i]        = !mismatch;
        end
      end
      len_d = len_q + 5'd1;
    end

    if (bks_en) begin
      for (int i = 0; i < LEN; i++) begin
        if (len_q == 5'(i + 1)) begin
          typed_d[i*CW +: CW] = '0;
          correct_d[i]        = 1'b0;
        end
      end
      len_d = len_q - 5'd1;
    end

    // Completion is judged on the post-key values so the last correct
    // keystroke and a coincident time_up both land in DONE on this edge.
    if ((state_q == TYPING) && (bus.time_up || ((len_d == C_LEN) && (&correct_d))))
      state_d = DONE;

    if (bus.clear) begin
      state_d   = IDLE;
      typed_d   = '0;
      correct_d = '0;
      len_d     = '0;
      ks_d      = '0;
      err_d     = '0;
      tgt_d     = '0;
      start_d   = 1'b0;
    end

    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      typed_q   <= '0;
      correct_q <= '0;
      len_q     <= '0;
      ks_q      <= '0;
      err_q     <= '0;
      tgt_q     <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      typed_q   <= typed_d;
      correct_q <= correct_d;
      len_q     <= len_d;
      ks_q      <= ks_d;
      err_q     <= err_d;
      tgt_q     <= tgt_d;
      start_q   <= start_d;
      done_q    <= done_d;
    end
  end

  assign bus.typed      = typed_q;
  assign bus.correct    = correct_q;
  assign bus.len        = len_q;
  assign bus.keystrokes = ks_q;
  assign bus.errors     = err_q;
  assign bus.state      = state_q;
  assign bus.start      = start_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_type_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_type_buffer
// Description : Directed self-checking bench for type_buffer, LEN=3 build.
//               Expected values are hand-computed from the sentence "cat".
// Revision    : 1.0 - initial release
// ============================================================================
module tb_type_buffer;

  localparam int LEN = 3;
  localparam int CW  = 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  type_buffer_if #(.LEN(LEN), .CW(CW)) bus ();

  type_buffer #(.LEN(LEN), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [LEN*CW-1:0] CAT = {5'd20, 5'd1, 5'd3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; outputs are sampled 1ns after the edge.
  task automatic drive(input logic kv, input logic [CW-1:0] code, input logic tu, input logic clr);
    @(negedge clk);
    bus.key_valid = kv;
    bus.key_code  = code;
    bus.time_up   = tu;
    bus.clear     = clr;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.time_up   = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".typed"},   64'(bus.typed),      64'd0);
    chk({tag, ".correct"}, 64'(bus.correct),    64'd0);
    chk({tag, ".len"},     64'(bus.len),        64'd0);
    chk({tag, ".ks"},      64'(bus.keystrokes), 64'd0);
    chk({tag, ".err"},     64'(bus.errors),     64'd0);
    chk({tag, ".state"},   64'(bus.state),      64'd0);
    chk({tag, ".start"},   64'(bus.start),      64'd0);
    chk({tag, ".done"},    64'(bus.done),       64'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.target    = '0;
    bus.time_up   = 1'b0;
    bus.clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores backspace, code 0, ignored codes and time_up
    bus.target = CAT;
    drive(1'b1, 5'd31, 1'b0, 1'b0);
    chk("idle_bksp.state", 64'(bus.state), 64'd0);
    chk("idle_bksp.start", 64'(bus.start), 64'd0);
    drive(1'b1, 5'd0, 1'b0, 1'b0);
    chk("idle_zero.len",   64'(bus.len),   64'd0);
    chk("idle_zero.start", 64'(bus.start), 64'd0);
    drive(1'b1, 5'd29, 1'b0, 1'b0);
    chk("idle_29.state",   64'(bus.state), 64'd0);
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    chk("idle_tu.state",   64'(bus.state), 64'd0);
    chk("idle_tu.done",    64'(bus.done),  64'd0);
    chk("idle_tu.ks",      64'(bus.keystrokes), 64'd0);

    // "cat" typed correctly; target changes after latch must not matter
    drive(1'b1, 5'd3, 1'b0, 1'b0);
    chk("cat1.start", 64'(bus.start), 64'd1);
    chk("cat1.state", 64'(bus.state), 64'd1);
    chk("cat1.len",   64'(bus.len),   64'd1);
    chk("cat1.typed", 64'(bus.typed), 64'd3);
    bus.target = '0;
    drive(1'b1, 5'd1, 1'b0, 1'b0);
    chk("cat2.start", 64'(bus.start), 64'd0);
    chk("cat2.corr",  64'(bus.correct), 64'b011);
    drive(1'b1, 5'd20, 1'b0, 1'b0);
    chk("cat3.typed", 64'(bus.typed),   64'(CAT));
    chk("cat3.corr",  64'(bus.correct), 64'b111);
    chk("cat3.len",   64'(bus.len),     64'd3);
    chk("cat3.state", 64'(bus.state),   64'd2);
    chk("cat3.done",  64'(bus.done),    64'd1);
    chk("cat3.ks",    64'(bus.keystrokes), 64'd3);
    chk("cat3.err",   64'(bus.errors),  64'd0);
    drive(1'b1, 5'd31, 1'b0, 1'b0);
    chk("done_bksp.len",   64'(bus.len),   64'd3);
    chk("done_bksp.typed", 64'(bus.typed), 64'(CAT));
    drive(1'b1, 5'd5, 1'b0, 1'b0);
    chk("done_key.ks",     64'(bus.keystrokes), 64'd3);
    chk("done_key.state",  64'(bus.state), 64'd2);

    drive(1'b0, 5'd0, 1'b0, 1'b1);
    chk_reset("clr1");
    bus.target = CAT;

`ifndef STRICT_INPUT_EN
    // Mismatch, backspace, correction
    drive(1'b1, 5'd3, 1'b0, 1'b0);
    drive(1'b1, 5'd2, 1'b0, 1'b0);
    chk("mis.corr", 64'(bus.correct), 64'b001);
    chk("mis.err",  64'(bus.errors),  64'd1);
    chk("mis.len",  64'(bus.len),     64'd2);
    drive(1'b1, 5'd31, 1'b0, 1'b0);
    chk("bks.len",   64'(bus.len),     64'd1);
    chk("bks.typed", 64'(bus.typed),   64'd3);
    chk("bks.corr",  64'(bus.correct), 64'b001);
    chk("bks.ks",    64'(bus.keystrokes), 64'd2);
    drive(1'b1, 5'd1, 1'b0, 1'b0);
    chk("fix.corr",  64'(bus.correct), 64'b011);
    chk("fix.len",   64'(bus.len),     64'd2);
    chk("fix.ks",    64'(bus.keystrokes), 64'd3);
    chk("fix.err",   64'(bus.errors),  64'd1);
    chk("fix.state", 64'(bus.state),   64'd1);
    drive(1'b0, 5'd0, 1'b0, 1'b1);
    chk_reset("clr2");

    // Full buffer with a slot-0 mismatch, extra key, then time_up
    drive(1'b1, 5'd4, 1'b0, 1'b0);
    drive(1'b1, 5'd1, 1'b0, 1'b0);
    drive(1'b1, 5'd20, 1'b0, 1'b0);
    chk("full.corr",  64'(bus.correct), 64'b110);
    chk("full.state", 64'(bus.state),   64'd1);
    chk("full.ks",    64'(bus.keystrokes), 64'd3);
    chk("full.err",   64'(bus.errors),  64'd1);
    drive(1'b1, 5'd5, 1'b0, 1'b0);
    chk("extra.len",   64'(bus.len),   64'd3);
    chk("extra.ks",    64'(bus.keystrokes), 64'd3);
    chk("extra.typed", 64'(bus.typed), 64'({5'd20, 5'd1, 5'd4}));
    chk("extra.state", 64'(bus.state), 64'd1);
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    chk("tu.state", 64'(bus.state), 64'd2);
    chk("tu.done",  64'(bus.done),  64'd1);
    drive(1'b1, 5'd31, 1'b0, 1'b0);
    chk("tu_bksp.len", 64'(bus.len), 64'd3);
    drive(1'b0, 5'd0, 1'b0, 1'b1);
    chk_reset("clr3");

    // Key and time_up in the same cycle: key lands, then DONE
    drive(1'b1, 5'd3, 1'b0, 1'b0);
    drive(1'b1, 5'd27, 1'b1, 1'b0);
    chk("coin.typed", 64'(bus.typed),   64'({5'd0, 5'd27, 5'd3}));
    chk("coin.corr",  64'(bus.correct), 64'b001);
    chk("coin.len",   64'(bus.len),     64'd2);
    chk("coin.ks",    64'(bus.keystrokes), 64'd2);
    chk("coin.err",   64'(bus.errors),  64'd1);
    chk("coin.state", 64'(bus.state),   64'd2);
    drive(1'b0, 5'd0, 1'b0, 1'b1);
    chk_reset("clr4");
`else
    // Strict input: a mismatching key is counted but not inserted
    drive(1'b1, 5'd2, 1'b0, 1'b0);
    chk("strict_mis.len",   64'(bus.len),   64'd0);
    chk("strict_mis.err",   64'(bus.errors), 64'd1);
    chk("strict_mis.ks",    64'(bus.keystrokes), 64'd1);
    chk("strict_mis.typed", 64'(bus.typed), 64'd0);
    drive(1'b1, 5'd3, 1'b0, 1'b0);
    chk("strict_ok.len",  64'(bus.len),     64'd1);
    chk("strict_ok.corr", 64'(bus.correct), 64'b001);
    chk("strict_ok.ks",   64'(bus.keystrokes), 64'd2);
    chk("strict_ok.err",  64'(bus.errors),  64'd1);
    drive(1'b0, 5'd0, 1'b0, 1'b1);
    chk_reset("strict_clr");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
